multicycle_alu: RTL and testbench
=================================

# multicycle_alu

Parametrised multi-cycle integer execution unit. Executes the single-cycle logic, arithmetic and shift functions plus sequential unsigned multiply and divide into internal Hi/Lo registers, all behind one start/done handshake. Sits between the control unit and the register-file write-back mux. Replaces the fixed 32-bit ALU/shifter/multiplier/HiLo cluster with one width-generic, handshaked block.

## Interface
- WIDTH, 32, datapath width in bits; must be a power of two, minimum 8.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; sampled on rising edge of clk.
- start  in  1  request strobe, sampled on rising edge of clk; accepted only in IDLE.
- funct  in  6  function code, sampled with start.
- dataA  in  WIDTH  first operand, sampled with start.
- dataB  in  WIDTH  second operand / shift amount, sampled with start.
- result  out  WIDTH  registered result; holds until the next done.
- busy  out  1  high while a MULTU/DIVU is iterating.
- done  out  1  one-cycle pulse: result valid, Hi/Lo updated.
- div_by_zero  out  1  registered with done; high only for DIVU with dataB == 0.

## Operation
- Function codes:
  - AND 36, OR 37, ADD 32, SUB 34 (wrap, no overflow flag).
  - SLT 42: signed compare → 1 or 0.
  - SRL 2: dataA >> dataB[log2(WIDTH)-1:0], logical.
  - MFHI 16, MFLO 18: return Hi/Lo.
  - MULTU 25, DIVU 27.
- Unknown funct: done pulses, result = 0, Hi/Lo unchanged.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: start with a single-cycle funct → DONE.
  - IDLE: start with MULTU → MUL; with DIVU → DIV.
  - MUL/DIV: iteration counter runs WIDTH cycles, then → DONE.
  - DONE: done = 1 for one cycle → IDLE.
- MULTU: shift-add, one partial-product bit per cycle. {Hi,Lo} = 2·WIDTH-bit product; result = Lo.
- DIVU: restoring, one quotient bit per cycle. Lo = quotient, Hi = remainder, result = quotient.
- DIVU with dataB == 0: still runs WIDTH cycles, then Lo = all ones, Hi = dataA, div_by_zero = 1.
- start while busy or in DONE: ignored, not queued.
- Operands are latched at accept; later changes on the inputs have no effect.
- Hi/Lo change only on a MULTU/DIVU completion or reset.
- Reset values: result 0, busy 0, done 0, div_by_zero 0, Hi 0, Lo 0, state IDLE.

## Timing
- Single-cycle op: start accepted at edge k; result and done valid after edge k+1.
- MULTU/DIVU accepted at edge k:
  - busy high after edges k+1 .. k+WIDTH.
  - done, result, Hi/Lo and div_by_zero update at edge k+WIDTH+1. Latency = WIDTH+1 cycles (33 at WIDTH=32).
- Earliest next accept: the edge after done deasserts (issue interval = latency + 1).
- MFHI/MFLO issued after done return the new Hi/Lo.
- Reset mid-operation: at the next edge, the iteration aborts; all outputs, Hi and Lo return to reset values; no done pulse.
- start and reset both active: reset wins.

## Configuration
- MULTICYCLE_ALU_DIVU_EN defined: DIVU datapath and DIV state are compiled in, behaving as above.
- Not defined: no divider logic. DIVU is treated as an unknown funct: done after 1 cycle, result 0, Hi/Lo unchanged, div_by_zero stays 0.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001 → result 0x00000000, done one cycle after start, busy never high.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → done at start+33 with result 0x00000001; then MFHI → 0xFFFFFFFE, MFLO → 0x00000001.
- DIVU 100 / 7 → Lo 14, Hi 2, div_by_zero 0. DIVU 5 / 0 → Lo 0xFFFFFFFF, Hi 5, div_by_zero 1 (macro defined). Without the macro: DIVU 100 / 7 → result 0 after 1 cycle, Hi/Lo unchanged.
- SLT 0xFFFFFFFF, 0x00000001 → 1. SRL 0x80000000 by 31 → 0x00000001. SRL 0x80000000 with dataB = 33 → 0x40000000 (low 5 bits only).
- start pulsed during MULTU busy → ignored, single done. Reset driven low at cycle 10 of a MULTU → busy 0 next edge, no done; MFHI/MFLO then → 0.
- Unknown funct 63 → done after 1 cycle, result 0, Hi/Lo unchanged from the prior MULTU.

Source files
------------

// File: rtl/multicycle_alu.sv
// ---------------------------------------------------------------------------
// multicycle_alu : handshaked ALU with shift-add MULTU and restoring DIVU (Hi/Lo)
// Optional divider: define MULTICYCLE_ALU_DIVU_EN.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd3;
`ifdef MULTICYCLE_ALU_DIVU_EN
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [5:0] F_DIVU = 6'd27;
`endif

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  // Multiply: work = {partial, multiplier}; add multiplicand on LSB, shift right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, a_q} : '0);

`ifdef MULTICYCLE_ALU_DIVU_EN
  // Divide: work = {remainder, dividend/quotient}; borrow in bit WIDTH rejects the subtract.
  logic [WIDTH:0] div_shift, div_diff;
  assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = funct;
          a_d   = dataA;
          b_d   = dataB;
          cnt_d = '0;
          if (funct == F_MULTU) begin
            state_d = S_MUL;
            work_d  = {{WIDTH{1'b0}}, dataB};
`ifdef MULTICYCLE_ALU_DIVU_EN
          end else if (funct == F_DIVU) begin
            state_d = S_DIV;
            work_d  = {{WIDTH{1'b0}}, dataA};
`endif
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        busy_d = 1'b1;
        work_d = {mul_sum, work_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
`ifdef MULTICYCLE_ALU_DIVU_EN
      S_DIV: begin
        busy_d = 1'b1;
        if (!div_diff[WIDTH]) work_d = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
        else                  work_d = {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        done_d  = 1'b1;
        dbz_d   = 1'b0;
        state_d = S_IDLE;
        case (op_q)
          F_AND:   result_d = a_q & b_q;
          F_OR:    result_d = a_q | b_q;
          F_ADD:   result_d = a_q + b_q;
          F_SUB:   result_d = a_q - b_q;
          F_SLT:   result_d = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
          F_SRL:   result_d = a_q >> b_q[SHW-1:0];
          F_MFHI:  result_d = hi_q;
          F_MFLO:  result_d = lo_q;
          F_MULTU: begin
            result_d = work_q[WIDTH-1:0];
            lo_d     = work_q[WIDTH-1:0];
            hi_d     = work_q[2*WIDTH-1:WIDTH];
          end
`ifdef MULTICYCLE_ALU_DIVU_EN
          F_DIVU: begin
            result_d = work_q[WIDTH-1:0];
            lo_d     = work_q[WIDTH-1:0];
            hi_d     = work_q[2*WIDTH-1:WIDTH];
            dbz_d    = (b_q == '0);
          end
`endif
          default: result_d = '0;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result      = result_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_alu.sv
// ---------------------------------------------------------------------------
// tb_multicycle_alu : directed self-checking bench for multicycle_alu (WIDTH=32)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] dataA, dataB;
  logic [31:0] result;
  logic        busy, done, div_by_zero;

  int tests = 0;
  int fails = 0;
  int lat, bcnt, dcnt;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .funct       (funct),
    .dataA       (dataA),
    .dataB       (dataB),
    .result      (result),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the operand inputs after accept, wait (bounded) for done.
  // A nonzero poke raises start for one edge at that cycle count.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int poke, output int l, output int bc);
    start = 1'b1; funct = f; dataA = a; dataB = b;
    @(posedge clk); #1;
    start = 1'b0; funct = 6'd32; dataA = ~a; dataB = ~b;
    l = 0; bc = 0;
    while (done !== 1'b1 && l < 100) begin
      @(posedge clk); #1;
      start = 1'b0;
      l++;
      if (busy === 1'b1) bc++;
      if (l == poke) begin
        start = 1'b1; funct = 6'd32; dataA = 32'd1; dataB = 32'd1;
      end
    end
  endtask

  task automatic count_done(input int n, output int dc);
    dc = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dc++;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; funct = '0; dataA = '0; dataB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(6'd16, 32'h0, 32'h0, 0, lat, bcnt);
    chk("rst_mfhi", result, 32'h0);

    run_op(6'd32, 32'hFFFF_FFFF, 32'h0000_0001, 0, lat, bcnt);
    chk("add_wrap", result, 32'h0);
    chk("add_lat", lat, 32'd1);
    chk("add_busy", bcnt, 32'd0);

    run_op(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, lat, bcnt);
    chk("mul_result", result, 32'h0000_0001);
    chk("mul_lat", lat, 32'd33);
    chk("mul_busy_cycles", bcnt, 32'd32);
    count_done(4, dcnt);
    chk("mul_single_done", dcnt, 32'd0);
    run_op(6'd16, 32'h0, 32'h0, 0, lat, bcnt);
    chk("mul_mfhi", result, 32'hFFFF_FFFE);
    run_op(6'd18, 32'h0, 32'h0, 0, lat, bcnt);
    chk("mul_mflo", result, 32'h0000_0001);

    run_op(6'd42, 32'hFFFF_FFFF, 32'h0000_0001, 0, lat, bcnt);
    chk("slt_neg", result, 32'd1);
    run_op(6'd42, 32'h0000_0001, 32'hFFFF_FFFF, 0, lat, bcnt);
    chk("slt_pos", result, 32'd0);
    run_op(6'd2, 32'h8000_0000, 32'd31, 0, lat, bcnt);
    chk("srl_31", result, 32'h0000_0001);
    run_op(6'd2, 32'h8000_0000, 32'd33, 0, lat, bcnt);
    chk("srl_33", result, 32'h4000_0000);
    run_op(6'd36, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, lat, bcnt);
    chk("and", result, 32'hF000_F000);
    run_op(6'd37, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, lat, bcnt);
    chk("or", result, 32'hFFF0_FFF0);
    run_op(6'd34, 32'h0000_0000, 32'h0000_0001, 0, lat, bcnt);
    chk("sub_wrap", result, 32'hFFFF_FFFF);

    run_op(6'd63, 32'h1234_5678, 32'h9ABC_DEF0, 0, lat, bcnt);
    chk("unk_result", result, 32'h0);
    chk("unk_lat", lat, 32'd1);
    run_op(6'd16, 32'h0, 32'h0, 0, lat, bcnt);
    chk("unk_mfhi", result, 32'hFFFF_FFFE);
    run_op(6'd18, 32'h0, 32'h0, 0, lat, bcnt);
    chk("unk_mflo", result, 32'h0000_0001);

`ifdef MULTICYCLE_ALU_DIVU_EN
    run_op(6'd27, 32'd100, 32'd7, 0, lat, bcnt);
    chk("div_result", result, 32'd14);
    chk("div_lat", lat, 32'd33);
    chk("div_dbz", {31'd0, div_by_zero}, 32'd0);
    run_op(6'd16, 32'h0, 32'h0, 0, lat, bcnt);
    chk("div_mfhi", result, 32'd2);
    run_op(6'd18, 32'h0, 32'h0, 0, lat, bcnt);
    chk("div_mflo", result, 32'd14);
    run_op(6'd27, 32'd5, 32'd0, 0, lat, bcnt);
    chk("div0_result", result, 32'hFFFF_FFFF);
    chk("div0_dbz", {31'd0, div_by_zero}, 32'd1);
    run_op(6'd16, 32'h0, 32'h0, 0, lat, bcnt);
    chk("div0_mfhi", result, 32'd5);
`else
    run_op(6'd27, 32'd100, 32'd7, 0, lat, bcnt);
    chk("nodiv_result", result, 32'h0);
    chk("nodiv_lat", lat, 32'd1);
    chk("nodiv_dbz", {31'd0, div_by_zero}, 32'd0);
    run_op(6'd16, 32'h0, 32'h0, 0, lat, bcnt);
    chk("nodiv_mfhi", result, 32'hFFFF_FFFE);
    run_op(6'd18, 32'h0, 32'h0, 0, lat, bcnt);
    chk("nodiv_mflo", result, 32'h0000_0001);
`endif

    run_op(6'd25, 32'h1234_5678, 32'h0000_0100, 0, lat, bcnt);
    chk("latch_mul_result", result, 32'h3456_7800);
    run_op(6'd16, 32'h0, 32'h0, 0, lat, bcnt);
    chk("latch_mul_mfhi", result, 32'h0000_0012);

    // Reset during the tenth cycle of a MULTU
    start = 1'b1; funct = 6'd25; dataA = 32'd7; dataB = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_result", result, 32'h0);
    reset = 1'b1;
    count_done(40, dcnt);
    chk("mid_rst_no_done", dcnt, 32'd0);
    run_op(6'd16, 32'h0, 32'h0, 0, lat, bcnt);
    chk("mid_rst_mfhi", result, 32'h0);
    run_op(6'd18, 32'h0, 32'h0, 0, lat, bcnt);
    chk("mid_rst_mflo", result, 32'h0);

    // start and reset together: reset wins, nothing is accepted
    reset = 1'b0; start = 1'b1; funct = 6'd32; dataA = 32'd3; dataB = 32'd4;
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
    count_done(3, dcnt);
    chk("rst_beats_start", dcnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
